// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if
// Bundles the three requester channels (IF, LD, ST) and the byte-wide RAM
// port that the arbiter owns.
//   if_*  : instruction fetch, always a 4-byte read
//   ld_*  : load unit, 1/2/4-byte read, data zero-extended
//   st_*  : store unit, 1/2/4-byte write, byte k = st_data[8k+7:8k]
//   mem_* : RAM port; mem_din reflects the address presented last cycle
// slave  : the arbiter side
// master : requesters + RAM side (testbench / surrounding core)
interface ram_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;

  logic        ld_req;
  logic [31:0] ld_addr;
  logic [2:0]  ld_len;
  logic        ld_done;
  logic [31:0] ld_data;

  logic        st_req;
  logic [31:0] st_addr;
  logic [2:0]  st_len;
  logic [31:0] st_data;
  logic        st_done;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  if_req, if_addr, ld_req, ld_addr, ld_len,
           st_req, st_addr, st_len, st_data, mem_din,
    output if_done, if_data, ld_done, ld_data, st_done,
           mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, ld_req, ld_addr, ld_len,
           st_req, st_addr, st_len, st_data, mem_din,
    input  if_done, if_data, ld_done, ld_data, st_done,
           mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Shares one byte-wide RAM port between instruction fetch, load and store.
// Multi-byte accesses are sequenced little-endian, one byte per cycle.
// Arbitration is fixed priority ST > LD > IF, except that IF jumps to the
// front after STARVE_LIMIT consecutive losses in IDLE.
// Ports:
//   clk_in          rising-edge clock
//   rst_in          asynchronous active-low reset
//   rdy_in          global ready; 0 freezes state, counters and starve
//   flush           aborts an IF read in flight, masks if_req in IDLE
//   io_buffer_full  stalls writes whose address is >= IO_BASE
//   bus             requester channels + RAM port (slave modport)
module ram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter logic [31:0] IO_BASE      = 32'h0003_0000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush,
  input  logic              io_buffer_full,
  ram_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 2);
  localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
  typedef enum logic [1:0] {OWN_IF, OWN_LD, OWN_ST} owner_t;

  state_t          state, state_n;
  owner_t          owner;
  logic [31:0]     addr;
  logic [2:0]      len, cnt, last;
  logic [3:0][7:0] sdata, rbuf;
  logic            issued_q, rd_full;
  logic [1:0]      issued_idx;
  logic [SW-1:0]   starve;

  logic if_live, grant_if, grant_ld, grant_st;
  logic io_stall, issue, cap, cap_last, if_abort;

  // Anything other than 1 or 2 bytes is a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] l);
    return (l == 3'd1 || l == 3'd2) ? l : 3'd4;
  endfunction

  always_comb begin
    if_live  = bus.if_req && !flush;
    grant_if = if_live && ((starve >= LIMIT) || (!bus.st_req && !bus.ld_req));
    grant_st = !grant_if && bus.st_req;
    grant_ld = !grant_if && !bus.st_req && bus.ld_req;
    last     = len - 3'd1;
    io_stall = (addr >= IO_BASE) && io_buffer_full;
    issue    = (state == READ) && rdy_in && (cnt < len);
    if_abort = flush && (state == READ) && (owner == OWN_IF);
    // A byte issued last cycle lands now; this is independent of rdy_in so
    // a pause never loses a byte already on the RAM bus.
    cap      = issued_q && (state == READ);
    cap_last = cap && ({1'b0, issued_idx} == last);
  end

  always_comb begin
    state_n = state;
    if (if_abort) begin
      state_n = IDLE;
    end else if (rdy_in) begin
      case (state)
        IDLE:    if (grant_st) state_n = WRITE;
                 else if (grant_ld || grant_if) state_n = READ;
        READ:    if (rd_full || cap_last) state_n = DONE;
        WRITE:   if (!io_stall && cnt == last) state_n = DONE;
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_n;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      owner      <= OWN_IF;
      addr       <= '0;
      len        <= 3'd4;
      cnt        <= '0;
      sdata      <= '0;
      rbuf       <= '0;
      issued_q   <= 1'b0;
      issued_idx <= '0;
      rd_full    <= 1'b0;
      starve     <= '0;
    end else begin
      issued_q   <= issue && !if_abort;
      issued_idx <= cnt[1:0];
      if (cap) begin
        rbuf[issued_idx] <= bus.mem_din;
        // Last byte may land while rdy_in is low; remember it for the exit.
        if (cap_last) rd_full <= 1'b1;
      end
      if (rdy_in) begin
        case (state)
          IDLE: begin
            if (!if_live || grant_if)  starve <= '0;
            else if (starve < LIMIT)   starve <= starve + SW'(1);
            if (grant_if || grant_ld || grant_st) begin
              cnt     <= '0;
              rbuf    <= '0;        // unused upper bytes read back as zero
              rd_full <= 1'b0;
              if (grant_st) begin
                owner <= OWN_ST;
                addr  <= bus.st_addr;
                len   <= norm_len(bus.st_len);
                sdata <= bus.st_data;
              end else if (grant_ld) begin
                owner <= OWN_LD;
                addr  <= bus.ld_addr;
                len   <= norm_len(bus.ld_len);
              end else begin
                owner <= OWN_IF;
                addr  <= bus.if_addr;
                len   <= 3'd4;
              end
            end
          end
          READ:    if (cnt < len) cnt <= cnt + 3'd1;
          WRITE:   if (!io_stall && cnt != last) cnt <= cnt + 3'd1;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.mem_a    = addr + {29'd0, cnt};
    bus.mem_wr   = (state == WRITE) && rdy_in && !io_stall;
    bus.mem_dout = sdata[cnt[1:0]];
    bus.if_done  = (state == DONE) && (owner == OWN_IF) && !flush;
    bus.ld_done  = (state == DONE) && (owner == OWN_LD);
    bus.st_done  = (state == DONE) && (owner == OWN_ST);
    bus.if_data  = ((state == DONE) && (owner == OWN_IF) && !flush) ? rbuf : '0;
    bus.ld_data  = ((state == DONE) && (owner == OWN_LD)) ? rbuf : '0;
  end
endmodule
